// File: rtl/bank_reg_arbiter.sv
// Serialises single-port bank access between the AHB host and N_REQ internal requesters.
// 3 cycles per transaction (grant, access, done+ack); requesters hold req stable until their one-cycle ack.
module bank_reg_arbiter #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 32,
  parameter int N_REQ           = 3,
  parameter int HOST_MAX_CONSEC = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    h_req,
  input  logic                    h_we,
  input  logic [ADDR_W-1:0]       h_addr,
  input  logic [DATA_W-1:0]       h_wdata,
  output logic                    h_ack,
  output logic [DATA_W-1:0]       h_rdata,
  input  logic [N_REQ-1:0]        r_req,
  input  logic [N_REQ-1:0]        r_we,
  input  logic [N_REQ*ADDR_W-1:0] r_addr,
  input  logic [N_REQ*DATA_W-1:0] r_wdata,
  output logic [N_REQ-1:0]        r_ack,
  output logic [DATA_W-1:0]       r_rdata,
  output logic [ADDR_W-1:0]       bank_addr_w,
  output logic [ADDR_W-1:0]       bank_addr_r,
  output logic                    bank_we,
  output logic [DATA_W-1:0]       bank_wdata,
  input  logic [DATA_W-1:0]       bank_rdata,
  output logic [3:0]              gnt_id,
  output logic                    busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]        host_cnt;
  logic [PW-1:0]     rr_ptr, cur_idx, int_idx, cand;
  logic              cur_host, cur_we, int_found, host_win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Host loses priority only once it has used its consecutive-grant budget while internals wait.
  assign host_win = h_req && !((host_cnt == 4'(HOST_MAX_CONSEC)) && (|r_req));

  always_comb begin
    int_found = 1'b0;
    int_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!int_found && r_req[cand]) begin
        int_found = 1'b1;
        int_idx   = cand;
      end
    end
  end

  always_comb begin
    win_we    = h_we;
    win_addr  = h_addr;
    win_wdata = h_wdata;
    if (!host_win) begin
      win_we    = r_we[int_idx];
      win_addr  = ADDR_W'(r_addr >> (int_idx * ADDR_W));
      win_wdata = DATA_W'(r_wdata >> (int_idx * DATA_W));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host_win || int_found) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      host_cnt    <= '0;
      rr_ptr      <= PW'(N_REQ - 1);
      cur_idx     <= '0;
      cur_host    <= 1'b0;
      cur_we      <= 1'b0;
      h_ack       <= 1'b0;
      h_rdata     <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      bank_addr_w <= '0;
      bank_addr_r <= '0;
      bank_we     <= 1'b0;
      bank_wdata  <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
    end else begin
      h_ack <= 1'b0;
      r_ack <= '0;
      case (state)
        IDLE: if (host_win || int_found) begin
          busy     <= 1'b1;
          cur_host <= host_win;
          cur_idx  <= int_idx;
          cur_we   <= win_we;
          bank_we  <= win_we;
          if (win_we) begin
            bank_addr_w <= win_addr;
            bank_wdata  <= win_wdata;
          end else begin
            bank_addr_r <= win_addr;
          end
          if (host_win) begin
            gnt_id <= 4'd1;
            if (!(|r_req))                              host_cnt <= '0;
            else if (host_cnt != 4'(HOST_MAX_CONSEC))   host_cnt <= host_cnt + 4'd1;
          end else begin
            gnt_id   <= 4'd2 + 4'(int_idx);
            rr_ptr   <= int_idx;
            host_cnt <= '0;
          end
        end
        ACCESS: bank_we <= 1'b0;
        DONE: begin
          busy   <= 1'b0;
          gnt_id <= '0;
          if (cur_host) begin
            h_ack <= 1'b1;
            if (!cur_we) h_rdata <= bank_rdata;
          end else begin
            r_ack <= N_REQ'(1) << cur_idx;
            if (!cur_we) r_rdata <= bank_rdata;
          end
        end
        default: bank_we <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_bank_reg_arbiter.sv
// Bench for bank_reg_arbiter: directed cases plus random traffic, checked every cycle against a
// transaction-timeline model (grant at t, bank strobe at t+1, ack at t+3) and a synchronous-read bank.
module tb_bank_reg_arbiter;
  localparam int AW = 8, DW = 32, NR = 3, HMAX = 4;

  logic           HCLK, HRESETn;
  logic           h_req, h_we, h_ack;
  logic [AW-1:0]  h_addr;
  logic [DW-1:0]  h_wdata, h_rdata;
  logic [NR-1:0]  r_req, r_we, r_ack;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_wdata;
  logic [DW-1:0]  r_rdata, bank_wdata, bank_rdata;
  logic [AW-1:0]  bank_addr_w, bank_addr_r;
  logic           bank_we, busy;
  logic [3:0]     gnt_id;

  bank_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(NR), .HOST_MAX_CONSEC(HMAX)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .r_req(r_req), .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata), .r_ack(r_ack), .r_rdata(r_rdata),
    .bank_addr_w(bank_addr_w), .bank_addr_r(bank_addr_r), .bank_we(bank_we),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .gnt_id(gnt_id), .busy(busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [DW-1:0] mem [256];
  int checks = 0, failures = 0, cyc = 0;
  int ack_log[$], ack_cyc[$];
  int h_left = 0, r_left[NR];
  logic h_cont = 0;
  logic [NR-1:0] r_cont = '0;

  // Reference model: one transaction at a time, described by its owner and the cycles since grant.
  int m_t = 0, m_own = 0, m_hcnt = 0, m_rr = NR - 1, w = 0, j = 0;
  logic m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic e_hack = 0, e_busy = 0, e_bwe = 0;
  logic [NR-1:0] e_rack = '0;
  logic [3:0] e_gnt = '0;
  logic [DW-1:0] e_hrd = '0, e_rrd = '0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_t = 0; m_own = 0; m_hcnt = 0; m_rr = NR - 1; m_we = 0;
      e_hack = 0; e_rack = '0; e_busy = 0; e_bwe = 0; e_gnt = '0; e_hrd = '0; e_rrd = '0;
    end else begin
      e_hack = 0; e_rack = '0;
      if (m_t == 0) begin
        w = 0;
        if (h_req && !(m_hcnt == HMAX && r_req != 0)) w = 1;
        else
          for (int k = 1; k <= NR; k++)
            if (w == 0 && ((32'(r_req) >> ((m_rr + k) % NR)) & 32'd1) != 0) w = 2 + (m_rr + k) % NR;
        if (w != 0) begin
          m_own = w; m_t = 1; e_busy = 1; e_gnt = 4'(w);
          if (w == 1) begin
            m_we = h_we; m_addr = h_addr; m_wdata = h_wdata;
            m_hcnt = (r_req == 0) ? 0 : ((m_hcnt < HMAX) ? m_hcnt + 1 : HMAX);
          end else begin
            j = w - 2;
            m_we = ((32'(r_we) >> j) & 32'd1) != 0;
            m_addr = AW'(r_addr >> (j * AW));
            m_wdata = DW'(r_wdata >> (j * DW));
            m_hcnt = 0; m_rr = j;
          end
          e_bwe = m_we;
        end
      end else if (m_t == 1) begin
        m_t = 2; e_bwe = 0;
      end else begin
        m_t = 0; e_busy = 0; e_gnt = '0;
        if (m_own == 1) begin
          e_hack = 1;
          if (!m_we) e_hrd = mem[m_addr];
        end else begin
          e_rack = NR'(1 << (m_own - 2));
          if (!m_we) e_rrd = mem[m_addr];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic agents();
    if (h_req && h_ack) h_req = 0;
    if (!h_req && h_left > 0 && (h_cont || $urandom_range(0, 2) == 0)) begin
      h_req = 1; h_left--;
      h_we = 1'($urandom_range(0, 1)); h_addr = AW'($urandom_range(0, 15)); h_wdata = $urandom;
    end
    for (int i = 0; i < NR; i++) begin
      if (r_req[i] && r_ack[i]) r_req[i] = 0;
      if (!r_req[i] && r_left[i] > 0 && (r_cont[i] || $urandom_range(0, 2) == 0)) begin
        r_req[i] = 1; r_left[i]--;
        r_we[i] = 1'($urandom_range(0, 1));
        r_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        r_wdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  // One clock: synchronous-read bank, per-cycle compare against the model, ack logging, agents.
  task automatic step();
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic we;
    ra = bank_addr_r; wa = bank_addr_w; wd = bank_wdata; we = bank_we;
    @(posedge HCLK);
    #1;
    cyc++;
    if (we && HRESETn) mem[wa] = wd;
    bank_rdata = mem[ra];
    chk("h_ack", 32'(h_ack), 32'(e_hack));
    chk("r_ack", 32'(r_ack), 32'(e_rack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("gnt_id", 32'(gnt_id), 32'(e_gnt));
    chk("bank_we", 32'(bank_we), 32'(e_bwe));
    chk("h_rdata", h_rdata, e_hrd);
    chk("r_rdata", r_rdata, e_rrd);
    chk("one_ack", 32'($countones({h_ack, r_ack}) <= 1), 32'd1);
    if (m_t == 1 && m_we) begin
      chk("bank_addr_w", 32'(bank_addr_w), 32'(m_addr));
      chk("bank_wdata", bank_wdata, m_wdata);
    end
    if (m_t == 1 && !m_we) chk("bank_addr_r", 32'(bank_addr_r), 32'(m_addr));
    if (h_ack) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
    for (int i = 0; i < NR; i++)
      if (r_ack[i]) begin ack_log.push_back(2 + i); ack_cyc.push_back(cyc); end
    agents();
  endtask

  task automatic do_reset();
    HRESETn = 0;
    h_req = 0; r_req = '0; h_left = 0; h_cont = 0; r_cont = '0;
    for (int i = 0; i < NR; i++) r_left[i] = 0;
    repeat (2) step();
    HRESETn = 1;
    ack_log.delete(); ack_cyc.delete();
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while (ack_log.size() < n && c < budget) begin step(); c++; end
    chk("ack_wait", 32'(ack_log.size() >= n), 32'd1);
  endtask

  task automatic drain(input int budget);
    int c = 0, pend;
    pend = 1;
    while (pend != 0 && c < budget) begin
      pend = h_left + 32'(h_req) + 32'(r_req != 0) + 32'(busy);
      for (int i = 0; i < NR; i++) pend += r_left[i];
      if (pend != 0) begin step(); c++; end
    end
    chk("drain", 32'(pend == 0), 32'd1);
  endtask

  int rot_exp [9]  = '{2, 3, 4, 2, 3, 4, 2, 3, 4};
  int host_exp [10] = '{1, 1, 1, 1, 4, 1, 1, 1, 1, 4};

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    h_we = 0; h_addr = '0; h_wdata = '0; r_we = '0; r_addr = '0; r_wdata = '0; bank_rdata = '0;
    do_reset();

    // Host write: strobe in the access cycle, ack three clocks after the request.
    h_req = 1; h_we = 1; h_addr = 8'h10; h_wdata = 32'hDEADBEEF;
    step();
    chk("w_gnt", 32'(gnt_id), 32'd1);
    chk("w_we", 32'(bank_we), 32'd1);
    chk("w_addr", 32'(bank_addr_w), 32'h10);
    chk("w_data", bank_wdata, 32'hDEADBEEF);
    step();
    chk("w_we_drop", 32'(bank_we), 32'd0);
    step();
    chk("w_hack", 32'(h_ack), 32'd1);
    chk("w_gnt_clr", 32'(gnt_id), 32'd0);

    // Internal 1 read from a known location.
    mem[8'h20] = 32'h12345678;
    r_req = 3'b010; r_we = 3'b000; r_addr[15:8] = 8'h20;
    step();
    chk("r_gnt", 32'(gnt_id), 32'd3);
    chk("r_addr", 32'(bank_addr_r), 32'h20);
    chk("r_we0", 32'(bank_we), 32'd0);
    step();
    chk("r_we1", 32'(bank_we), 32'd0);
    step();
    chk("r_ack", 32'(r_ack), 32'b010);
    chk("r_data", r_rdata, 32'h12345678);
    chk("r_hrd", h_rdata, 32'd0);

    // Round robin with all internal requests held.
    do_reset();
    r_cont = 3'b111; for (int i = 0; i < NR; i++) r_left[i] = 3;
    agents();
    run_until(9, 200);
    for (int i = 0; i < 9; i++) chk("rr_order", 32'(ack_log[i]), 32'(rot_exp[i]));
    for (int i = 1; i < 9; i++) chk("rr_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    drain(100);

    // Host held with internal 2 held: host gets HMAX grants, then one internal.
    do_reset();
    h_cont = 1; h_left = 100; r_cont = 3'b100; r_left[2] = 100;
    agents();
    run_until(10, 300);
    for (int i = 0; i < 10; i++) chk("host_order", 32'(ack_log[i]), 32'(host_exp[i]));
    h_left = 0; r_left[2] = 0;
    drain(100);

    // Host and internal 0 together from reset.
    do_reset();
    h_cont = 1; h_left = 1; r_cont = 3'b001; r_left[0] = 1;
    agents();
    run_until(2, 50);
    chk("sim_first", 32'(ack_log[0]), 32'd1);
    chk("sim_second", 32'(ack_log[1]), 32'd2);
    drain(50);

    // Reset during the access cycle of a write.
    do_reset();
    r_req = 3'b001; r_we = 3'b001; r_addr[7:0] = 8'h05; r_wdata[31:0] = 32'hA5A5A5A5;
    step();
    chk("rst_we_pre", 32'(bank_we), 32'd1);
    #2 HRESETn = 0; r_req = '0;
    #1;
    chk("rst_we", 32'(bank_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_ack", 32'({h_ack, r_ack}), 32'd0);
    step();
    HRESETn = 1;
    ack_log.delete(); ack_cyc.delete();
    r_req = 3'b001; r_we = 3'b000;
    run_until(1, 20);
    chk("rst_regrant", 32'(ack_log[0]), 32'd2);
    drain(50);

    // Random mixed traffic.
    do_reset();
    h_left = 40; for (int i = 0; i < NR; i++) r_left[i] = 40;
    drain(5000);
    chk("rand_acks", 32'(ack_log.size()), 32'd160);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bank_reg_arbiter.md
Name: bank_reg_arbiter

Overview:
Arbitrates single-port access to the bank_reg register bank between the AHB slave controller (host port) and N_REQ internal requesters, such as the ADV7511 I2C configuration sequencer and the video-timing block. It serialises transactions and drives the bank write/read address, data and write-enable. It returns read data and a one-cycle acknowledge to the granted requester. The host has priority, bounded by an anti-starvation counter; internal requesters are served round-robin.

Parameters:
ADDR_W, 8, bank address width
DATA_W, 32, bank data width
N_REQ, 3, number of internal requesters (2..8)
HOST_MAX_CONSEC, 4, max consecutive host grants while any internal request is pending (1..15)

Ports:
HCLK  in  1  system clock, all logic on rising edge
HRESETn  in  1  asynchronous active-low reset
h_req  in  1  host request, held until h_ack
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_ack  out  1  host transfer complete, one-cycle pulse
h_rdata  out  DATA_W  host read data, valid with h_ack
r_req  in  N_REQ  internal requests, one bit per requester
r_we  in  N_REQ  internal write flags
r_addr  in  N_REQ*ADDR_W  packed internal addresses, requester i at [i*ADDR_W +: ADDR_W]
r_wdata  in  N_REQ*DATA_W  packed internal write data
r_ack  out  N_REQ  one-hot acknowledge pulse
r_rdata  out  DATA_W  shared internal read data, valid with r_ack
bank_addr_w  out  ADDR_W  bank write address
bank_addr_r  out  ADDR_W  bank read address
bank_we  out  1  bank write enable
bank_wdata  out  DATA_W  bank write data
bank_rdata  in  DATA_W  bank read data, valid one cycle after bank_addr_r
gnt_id  out  4  current owner: 0 = none, 1 = host, 2+i = internal i
busy  out  1  high while a transaction is in progress

Behaviour:
- All outputs are registered.
- Reset (HRESETn low, async): all outputs 0, FSM to IDLE, host_cnt 0, rr_ptr N_REQ-1 (so requester 0 wins first).
- FSM states: IDLE, ACCESS, DONE.
- IDLE: evaluate requests; if none, stay in IDLE. Otherwise latch winner id, we, addr and wdata, set busy, then go to ACCESS.
- Winner selection:
  - Host wins if h_req and not (host_cnt == HOST_MAX_CONSEC and |r_req).
  - Otherwise the internal winner is the first set r_req bit searching from rr_ptr+1 upward, modulo N_REQ.
- host_cnt:
  - Increments on each host grant while |r_req, saturating at HOST_MAX_CONSEC.
  - Clears on any internal grant, or when a host is granted with r_req == 0.
- rr_ptr updates to the index of an internal winner only; host grants leave it unchanged.
- ACCESS, write:
  - bank_addr_w = addr, bank_wdata = wdata, bank_we = 1 for exactly this cycle.
  - Go to DONE.
- ACCESS, read: bank_addr_r = addr, bank_we = 0, then go to DONE.
- DONE:
  - bank_we = 0.
  - For a read, capture bank_rdata into h_rdata or r_rdata (the other rdata holds its previous value).
  - Pulse the owner's ack for this cycle only, then go to IDLE. busy and gnt_id clear on entry to IDLE.
- Latency: request seen in IDLE at edge n, ack high in the cycle after edge n+2, giving 3 cycles per transaction.
- Back-to-back: a requester whose req is still high in the IDLE cycle after its ack is treated as a new request.
- Requester rules: req, we, addr and wdata must be held stable until ack; the arbiter latches them in IDLE, so later changes are ignored. Dropping req before ack does not abort the granted transaction; the ack still pulses.
- Simultaneous requests: host plus internal with host_cnt < max gives host the grant; all internal bits set rotates 0,1,2,0...
- Reset mid-transaction: bank_we drops immediately and no ack is issued; the write may or may not have reached the bank, which software handles.
- Width rules: no address range checking (the bank ignores unmapped addresses). gnt_id is always 4 bits; N_REQ above 8 is disallowed.
- At most one ack bit is high in any cycle.

Test Plan:
- Host write h_addr=0x10, h_wdata=0xDEADBEEF -> bank_we high for exactly 1 cycle with bank_addr_w=0x10, bank_wdata=0xDEADBEEF; h_ack 3 cycles after h_req; gnt_id=1 during transaction.
- Internal 1 read addr 0x20, bank returns 0x12345678 -> r_ack=3'b010 one cycle, r_rdata=0x12345678, h_rdata unchanged, bank_we never high.
- r_req=3'b111 held for 9 transactions, no host -> grant order 0,1,2,0,1,2,0,1,2; each ack 3 cycles apart.
- h_req held continuously with r_req[2] held, HOST_MAX_CONSEC=4 -> grants H,H,H,H,I2,H,H,H,H,I2; host_cnt saturates at 4 and clears after the I2 grant.
- h_req and r_req[0] asserted in the same cycle from reset -> host first, internal 0 second; no cycle with two acks.
- HRESETn pulled low during the ACCESS cycle of a write -> bank_we, busy, gnt_id and acks go to 0 asynchronously; after release, FSM is IDLE and the next r_req=3'b001 is granted normally.
